// File: rtl/drive_cmd_arbiter.sv
// Arbitrates the UART command byte between the manual FSM and the auto planner,
// inserting a forced-stop window on mode switches and a minimum hold per auto command.
module drive_cmd_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2000000,
    parameter int unsigned STOP_CYCLES = 10000000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_ok,
    input  logic       mode,
    input  logic [5:0] man_cmd,
    input  logic       auto_req,
    input  logic [5:0] auto_cmd,
    output logic       auto_ack,
    output logic [7:0] cmd_out,
    output logic [1:0] src,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STOP_CYCLES) ? HOLD_CYCLES : STOP_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MANUAL      = 3'd1,
        SWITCH_STOP = 3'd2,
        AUTO_WAIT   = 3'd3,
        AUTO_HOLD   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    pay_q, pay_d;
    logic [1:0]    src_q, src_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    function automatic logic [5:0] sanitise(input logic [5:0] c);
        logic [5:0] r;
        r = c;
        if (c[0] & c[1]) r[1:0] = 2'b00;
        if (c[2] & c[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        pay_d   = '0;
        src_d   = '0;
        busy_d  = 1'b0;

        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);

        if (!power_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = mode ? AUTO_WAIT : MANUAL;
                MANUAL: begin
                    if (mode) begin
                        state_d = SWITCH_STOP;
                        cnt_d   = STOP_LOAD;
                    end
                end
                SWITCH_STOP: begin
                    if (cnt_q == '0) state_d = mode ? AUTO_WAIT : MANUAL;
                end
                AUTO_WAIT: begin
                    if (!mode) begin
                        state_d = SWITCH_STOP;
                        cnt_d   = STOP_LOAD;
                    end else if (auto_req) begin
                        state_d = AUTO_HOLD;
                        cnt_d   = HOLD_LOAD;
                        ack_d   = 1'b1;
                    end
                end
                AUTO_HOLD: begin
                    if (!mode) begin
                        state_d = SWITCH_STOP;
                        cnt_d   = STOP_LOAD;
                    end else if (cnt_q == '0) begin
                        if (auto_req) begin
                            cnt_d = HOLD_LOAD;
                            ack_d = 1'b1;
                        end else begin
                            state_d = AUTO_WAIT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered outputs reflect the state being entered on this edge.
        case (state_d)
            MANUAL: begin
                pay_d = sanitise(man_cmd);
                src_d = 2'b01;
            end
            AUTO_WAIT: src_d = 2'b10;
            AUTO_HOLD: begin
                pay_d  = ack_d ? sanitise(auto_cmd) : pay_q;
                src_d  = 2'b10;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            src_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            src_q   <= src_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_out  = {2'b10, pay_q};
    assign src      = src_q;
    assign auto_ack = ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_drive_cmd_arbiter;

    localparam int HOLD = 4;
    localparam int STOP = 3;

    localparam int P_OFF  = 0;
    localparam int P_MAN  = 1;
    localparam int P_STOP = 2;
    localparam int P_WAIT = 3;
    localparam int P_HOLD = 4;

    logic       sys_clk  = 1'b0;
    logic       rst      = 1'b1;
    logic       power_ok = 1'b0;
    logic       mode     = 1'b0;
    logic [5:0] man_cmd  = 6'd0;
    logic       auto_req = 1'b0;
    logic [5:0] auto_cmd = 6'd0;
    logic       auto_ack;
    logic [7:0] cmd_out;
    logic [1:0] src;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    drive_cmd_arbiter #(.HOLD_CYCLES(HOLD), .STOP_CYCLES(STOP)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .power_ok(power_ok),
        .mode    (mode),
        .man_cmd (man_cmd),
        .auto_req(auto_req),
        .auto_cmd(auto_cmd),
        .auto_ack(auto_ack),
        .cmd_out (cmd_out),
        .src     (src),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: phase plus the number of cycles still owed to the current window.
    typedef struct packed {
        int         ph;
        int         left;
        logic [5:0] held;
        logic [7:0] cmd;
        logic [1:0] src;
        logic       busy;
        logic       ack;
    } model_t;

    localparam model_t M_RESET = '{ph: P_OFF, left: 0, held: 6'd0, cmd: 8'h80,
                                   src: 2'd0, busy: 1'b0, ack: 1'b0};

    model_t m;

    function automatic logic [5:0] clean(input logic [5:0] c);
        return c & ~{2'b00, {2{c[3] & c[2]}}, {2{c[1] & c[0]}}};
    endfunction

    function automatic model_t model_next(input model_t s, input logic pok, input logic md,
                                          input logic [5:0] mc, input logic rq,
                                          input logic [5:0] ac);
        model_t n;
        n = s;
        n.ack = 1'b0;
        if (!pok) begin
            n.ph = P_OFF;
            n.left = 0;
        end else begin
            case (s.ph)
                P_OFF:  n.ph = md ? P_WAIT : P_MAN;
                P_MAN:  if (md) begin n.ph = P_STOP; n.left = STOP; end
                P_STOP: if (s.left > 1) n.left = s.left - 1;
                        else n.ph = md ? P_WAIT : P_MAN;
                P_WAIT: begin
                    if (!md) begin n.ph = P_STOP; n.left = STOP; end
                    else if (rq) begin
                        n.ph = P_HOLD; n.left = HOLD; n.held = clean(ac); n.ack = 1'b1;
                    end
                end
                P_HOLD: begin
                    if (!md) begin n.ph = P_STOP; n.left = STOP; end
                    else if (s.left > 1) n.left = s.left - 1;
                    else if (rq) begin n.left = HOLD; n.held = clean(ac); n.ack = 1'b1; end
                    else n.ph = P_WAIT;
                end
                default: n.ph = P_OFF;
            endcase
        end
        n.cmd = 8'h80;
        n.src = 2'b00;
        n.busy = 1'b0;
        case (n.ph)
            P_MAN:  begin n.cmd = {2'b10, clean(mc)}; n.src = 2'b01; end
            P_WAIT: n.src = 2'b10;
            P_HOLD: begin n.cmd = {2'b10, n.held}; n.src = 2'b10; n.busy = 1'b1; end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge sys_clk or posedge rst) begin
        if (rst) m <= M_RESET;
        else     m <= model_next(m, power_ok, mode, man_cmd, auto_req, auto_cmd);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("model_cmd",  cmd_out,      m.cmd);
            chk("model_src",  8'(src),      8'(m.src));
            chk("model_busy", 8'(busy),     8'(m.busy));
            chk("model_ack",  8'(auto_ack), 8'(m.ack));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_cmd",  cmd_out,      8'h80);
        chk("rst_src",  8'(src),      8'h00);
        chk("rst_busy", 8'(busy),     8'h00);
        chk("rst_ack",  8'(auto_ack), 8'h00);

        // Reach AUTO_HOLD, then reset asynchronously mid-hold
        rst = 1'b0; power_ok = 1'b1; mode = 1'b1;
        tick();
        chk("first_wait_src", 8'(src), 8'h02);
        auto_req = 1'b1; auto_cmd = 6'b000010;
        tick();
        chk("pre_ack", 8'(auto_ack), 8'h01);
        chk("pre_cmd", cmd_out, 8'h82);
        auto_req = 1'b0;
        tick();
        chk("pre_busy", 8'(busy), 8'h01);
        rst = 1'b1;
        #1;
        chk("arst_cmd",  cmd_out,      8'h80);
        chk("arst_ack",  8'(auto_ack), 8'h00);
        chk("arst_src",  8'(src),      8'h00);
        chk("arst_busy", 8'(busy),     8'h00);
        mode = 1'b0; man_cmd = 6'd0;
        tick();
        rst = 1'b0;
        tick();
        chk("rel_src", 8'(src), 8'h01);

        // Manual passthrough and sanitise
        man_cmd = 6'b000101;
        tick();
        chk("man_85", cmd_out, 8'h85);
        man_cmd = 6'b001111;
        tick();
        chk("man_clean", cmd_out, 8'h80);
        chk("man_src", 8'(src), 8'h01);
        man_cmd = 6'b000101;
        tick();
        chk("man_85b", cmd_out, 8'h85);

        // Manual -> auto switch: three zero cycles, then AUTO_WAIT
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stop_cmd", cmd_out, 8'h80);
            chk("stop_src", 8'(src), 8'h00);
        end
        tick();
        chk("wait_src", 8'(src), 8'h02);
        chk("wait_cmd", cmd_out, 8'h80);

        auto_req = 1'b1; auto_cmd = 6'b000001;
        tick();
        chk("ack1", 8'(auto_ack), 8'h01);
        chk("hold1_cmd", cmd_out, 8'h81);
        chk("hold1_busy", 8'(busy), 8'h01);
        auto_cmd = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold1_cmd", cmd_out, 8'h81);
            chk("hold1_noack", 8'(auto_ack), 8'h00);
            chk("hold1_busy", 8'(busy), 8'h01);
        end
        tick();
        chk("b2b_ack", 8'(auto_ack), 8'h01);
        chk("b2b_cmd", cmd_out, 8'h84);
        auto_req = 1'b0;
        tick();
        chk("hold2_cmd", cmd_out, 8'h84);
        chk("hold2_noack", 8'(auto_ack), 8'h00);

        // Abort in cycle 2 of the hold
        mode = 1'b0; man_cmd = 6'b000110;
        tick();
        chk("abort_cmd", cmd_out, 8'h80);
        chk("abort_src", 8'(src), 8'h00);
        chk("abort_ack", 8'(auto_ack), 8'h00);
        tick();
        tick();
        chk("abort_stop3", cmd_out, 8'h80);
        tick();
        chk("abort_man_cmd", cmd_out, 8'h86);
        chk("abort_man_src", 8'(src), 8'h01);

        // Power loss during SWITCH_STOP, recovery straight to AUTO_WAIT
        mode = 1'b1;
        tick();
        chk("pl_stop_src", 8'(src), 8'h00);
        tick();
        power_ok = 1'b0;
        tick();
        chk("pl_idle_cmd", cmd_out, 8'h80);
        chk("pl_idle_src", 8'(src), 8'h00);
        power_ok = 1'b1;
        tick();
        chk("pl_wait_src", 8'(src), 8'h02);
        chk("pl_wait_busy", 8'(busy), 8'h00);

        // Mode switch beats a simultaneous request; mode toggles inside the window
        mode = 1'b0; auto_req = 1'b1; auto_cmd = 6'b110011;
        tick();
        chk("race_ack", 8'(auto_ack), 8'h00);
        chk("race_src", 8'(src), 8'h00);
        auto_req = 1'b0; mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        chk("toggle_still_stop", 8'(src), 8'h00);
        mode = 1'b1;
        tick();
        chk("toggle_exit_src", 8'(src), 8'h02);

        // Single command then expiry with no request pending
        auto_req = 1'b1;
        tick();
        chk("san_auto_cmd", cmd_out, 8'hB0);
        chk("san_auto_ack", 8'(auto_ack), 8'h01);
        auto_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold3_cmd", cmd_out, 8'hB0);
        end
        tick();
        chk("expire_cmd", cmd_out, 8'h80);
        chk("expire_src", 8'(src), 8'h02);
        chk("expire_busy", 8'(busy), 8'h00);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
